counter_ctrl: RTL

Front-end control stage that sits directly upstream of the lab 3-bit load/count core and drives its `cnt`, `load` and `num` inputs from raw board inputs. Two raw push-buttons are synchronised and debounced: a run button toggles run/pause and a load button issues a one-cycle load strobe. Three raw slide switches are synchronised and captured as the load value. A prescaler provides a count-enable tick so the core advances at a visible rate instead of every clock.

---
 rtl/lab_pkg.sv | 19 +
 rtl/counter_ctrl_if.sv | 29 ++
 rtl/counter_ctrl_debounce.sv | 48 ++++
 rtl/counter_ctrl.sv | 92 +++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// ----------------------------------------------------------------------------
// lab_pkg: shared widths and build-time defaults for the lab front-end (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package lab_pkg;

  localparam int NUM_W = 3;

  localparam int DEB_CYCLES_SIM   = 4;
  localparam int TICK_DIV_SIM     = 5;
  localparam int DEB_CYCLES_BOARD = 500000;
  localparam int TICK_DIV_BOARD   = 50000000;

  typedef logic [NUM_W-1:0] num_t;

endpackage

`default_nettype wire

// File: rtl/counter_ctrl_if.sv
// ----------------------------------------------------------------------------
// counter_ctrl_if: raw board inputs and core-facing controls of counter_ctrl (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

interface counter_ctrl_if;
  import lab_pkg::*;

  logic btn_run;
  logic btn_load;
  num_t sw_num;
  logic cnt;
  logic load;
  num_t num;
  logic tick;

  modport master (
    output btn_run, btn_load, sw_num,
    input  cnt, load, num, tick
  );

  modport slave (
    input  btn_run, btn_load, sw_num,
    output cnt, load, num, tick
  );

endinterface

`default_nettype wire

// File: rtl/counter_ctrl_debounce.sv
// ----------------------------------------------------------------------------
// debounce: 2-flop synchroniser, stability counter and rising-edge pulse (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module debounce
  import lab_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_SIM
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic db,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] stable_cnt;

  // db and rise change on the same edge, so a new level and its pulse align
  always_ff @(posedge clk) begin
    if (clr) begin
      sync       <= '0;
      stable_cnt <= '0;
      db         <= 1'b0;
      rise       <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      if (sync[1] == db) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        db         <= sync[1];
        rise       <= sync[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_ctrl.sv
// ----------------------------------------------------------------------------
// counter_ctrl: run/pause toggle, load strobe/value and count-enable prescaler (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module counter_ctrl
  import lab_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_SIM,
  parameter int TICK_DIV   = TICK_DIV_SIM
) (
  input  logic           clk,
  input  logic           clr,
  counter_ctrl_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic          run_db;
  logic          run_rise;
  logic          load_db;
  logic          load_rise;
  num_t          sw_meta;
  num_t          sw_sync;
  logic          run_level;
  logic          load_pulse;
  num_t          num_hold;
  logic          tick_pulse;
  logic [PW-1:0] pre;

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
    .clk  (clk),
    .clr  (clr),
    .din  (bus.btn_run),
    .db   (run_db),
    .rise (run_rise)
  );

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_load_deb (
    .clk  (clk),
    .clr  (clr),
    .din  (bus.btn_load),
    .db   (load_db),
    .rise (load_rise)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      sw_meta    <= '0;
      sw_sync    <= '0;
      run_level  <= 1'b1;
      load_pulse <= 1'b0;
      num_hold   <= '0;
      pre        <= '0;
      tick_pulse <= 1'b0;
    end else begin
      sw_meta    <= bus.sw_num;
      sw_sync    <= sw_meta;
      run_level  <= run_level ^ run_rise;
      load_pulse <= load_rise;
      if (load_rise) begin
        num_hold <= sw_sync;
      end
      // A load restarts the tick phase; a pausing run edge must not leave a tick behind
      if (load_rise) begin
        pre        <= '0;
        tick_pulse <= 1'b0;
      end else if (run_level) begin
        pre        <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        tick_pulse <= (pre == PRE_LAST) && !run_rise;
      end else begin
        tick_pulse <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      assert (!run_rise || run_db);
      assert (!load_rise || load_db);
    end
  end

  assign bus.cnt  = run_level;
  assign bus.load = load_pulse;
  assign bus.num  = num_hold;
  assign bus.tick = tick_pulse;

endmodule

`default_nettype wire
